uart_rx_os: RTL and testbench

Parametrised oversampling UART receiver, the next generation of the receive path in the UART top-level. It adds configurable data width, parity mode and oversampling ratio, majority-vote bit sampling, false-start rejection, break detection and a valid/ready output handshake with overrun reporting. It sits between the asynchronous `rxd` pin and the byte consumer, and will later be paired with a matching parametrised transmitter in the UART top-level.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_os.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_os.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants, FSM encoding and elaboration-time helpers for the UART receive/transmit paths.
// No logic of its own: no latency and no backpressure.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Nearest-integer clocks per oversample tick, never below 1.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    longint den;
    longint div;
    den = longint'(baud_rate) * longint'(oversample);
    div = (longint'(clk_freq) + den / 2) / den;
    if (div < 1) div = 1;
    return int'(div);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks, first pulse DIV clocks after reset.
// Never stalls and takes no backpressure; it is not resynchronised to frame starts.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = w_wrap;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote; word valid the edge after the stop-bit decision.
// Holds rx_valid until rx_ready; frames finishing while a word is held are dropped and flagged as overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SMP_A   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SMP_B   = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SMP_C   = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [3:0]     BIT_LAST = 4'(DATA_BITS - 1);

  logic                 w_tick;
  logic                 w_fall;
  logic                 w_maj;
  logic                 w_accept;
  logic                 w_done;
  logic                 w_xor;
  logic                 w_par_err;
  logic                 w_break;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_hist;
  logic                 r_armed;
  rx_state_t            r_state;
  logic [SCW-1:0]       r_sc;
  logic [3:0]           r_bitcnt;
  logic                 r_s0;
  logic                 r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_par_err;
  logic                 r_stop_err;
  logic                 r_break;
  logic                 r_overrun;

  uart_baud_tick #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  assign w_fall   = r_hist & ~r_sync2;
  assign w_maj    = maj3(r_s0, r_s1, r_sync2);
  assign w_accept = r_rx_valid & rx_ready;
  assign w_done   = w_tick && (r_sc == SMP_C) && (r_state == ST_STOP);
  assign w_xor    = ^{r_shift, r_par_bit};

  always_comb begin
    w_par_err = 1'b0;
    if (PARITY == PAR_EVEN) w_par_err = w_xor;
    else if (PARITY == PAR_ODD) w_par_err = ~w_xor;
  end

  // Break needs the stop sample itself to be low, hence w_maj rather than a stored bit.
  assign w_break = (r_shift == '0) && ((PARITY == PAR_NONE) || !r_par_bit) && !w_maj;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_hist     <= 1'b1;
      r_armed    <= 1'b1;
      r_state    <= ST_IDLE;
      r_sc       <= '0;
      r_bitcnt   <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
      r_break    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      if (r_sync2) r_armed <= 1'b1;

      if (r_state == ST_IDLE) begin
        if (w_fall && r_armed) begin
          r_state  <= ST_START;
          r_sc     <= '0;
          r_bitcnt <= '0;
        end
      end else if (w_tick) begin
        if (r_sc == SMP_A) r_s0 <= r_sync2;
        if (r_sc == SMP_B) r_s1 <= r_sync2;
        r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + SCW'(1);

        if (r_sc == SMP_C) begin
          case (r_state)
            ST_START:  if (w_maj) r_state <= ST_IDLE;
            ST_DATA:   r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            ST_PARITY: r_par_bit <= w_maj;
            default:   r_state <= ST_IDLE;
          endcase
        end else if (r_sc == SC_LAST) begin
          case (r_state)
            ST_START:  r_state <= ST_DATA;
            ST_DATA: begin
              if (r_bitcnt == BIT_LAST) r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              else r_bitcnt <= r_bitcnt + 4'd1;
            end
            ST_PARITY: r_state <= ST_STOP;
            default:   r_state <= ST_IDLE;
          endcase
        end
      end

      if (w_accept) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end

      // A word accepted this cycle frees the holding register for the completing frame.
      if (w_done) begin
        if (!w_maj) r_armed <= 1'b0;
        if (!r_rx_valid || w_accept) begin
          r_rx_data  <= r_shift;
          r_par_err  <= w_par_err;
          r_stop_err <= !w_maj;
          r_break    <= w_break;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign parity_error = r_par_err;
  assign stop_error   = r_stop_err;
  assign break_det    = r_break;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: 8E1 and 7O1 instances driven bit-by-bit, outputs compared against a frame-level model.
module tb_uart_rx_os;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int BIT      = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset8, rxd8, rdy8, val8, pe8, se8, bd8, ov8;
  logic [7:0] data8;
  logic       reset7, rxd7, rdy7, val7, pe7, se7, bd7, ov7;
  logic [6:0] data7;

  uart_rx_os #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1)
  ) u_dut8 (
    .clk(clk), .reset(reset8), .rxd(rxd8), .rx_data(data8), .rx_valid(val8),
    .rx_ready(rdy8), .parity_error(pe8), .stop_error(se8), .break_det(bd8), .overrun(ov8)
  );

  uart_rx_os #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(2)
  ) u_dut7 (
    .clk(clk), .reset(reset7), .rxd(rxd7), .rx_data(data7), .rx_valid(val7),
    .rx_ready(rdy7), .parity_error(pe7), .stop_error(se7), .break_det(bd7), .overrun(ov7)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Word layout: {break, stop_err, parity_err, data[8:0]}
  logic [11:0] obs8[$];
  logic [11:0] obs7[$];
  logic [11:0] exp8[$];
  logic [11:0] exp7[$];

  always @(negedge clk) begin
    if (val8 && rdy8) obs8.push_back({bd8, se8, pe8, 1'b0, data8});
    if (val7 && rdy7) obs7.push_back({bd7, se7, pe7, 2'b00, data7});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int count_ones(input logic [8:0] d, input int nb);
    int ones;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return ones;
  endfunction

  function automatic logic good_parity(input logic [8:0] d, input int nb, input int pm);
    int ones;
    ones = count_ones(d, nb);
    return (pm == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  function automatic logic [11:0] model(input logic [8:0] d, input int nb, input int pm,
                                        input logic pbit, input logic stopb);
    int ones;
    int sum;
    logic pe;
    logic bd;
    logic [8:0] dm;
    dm   = d & ((9'h1 << nb) - 9'h1);
    ones = count_ones(d, nb);
    sum  = (ones + int'(pbit)) % 2;
    pe   = 1'b0;
    if (pm == 1) pe = (sum != 0);
    else if (pm == 2) pe = (sum != 1);
    bd = (ones == 0) && (pm == 0 || !pbit) && !stopb;
    return {bd, !stopb, pe, dm};
  endfunction

  task automatic drive(input int dut, input logic v, input int clocks);
    if (dut == 8) rxd8 = v;
    else rxd7 = v;
    step(clocks);
  endtask

  task automatic send_frame(input int dut, input logic [8:0] d, input logic flip_par,
                            input logic stopb, input logic push_exp);
    int nb;
    int pm;
    logic pbit;
    nb   = (dut == 8) ? 8 : 7;
    pm   = (dut == 8) ? 1 : 2;
    pbit = good_parity(d, nb, pm) ^ flip_par;
    drive(dut, 1'b0, BIT);
    for (int i = 0; i < nb; i++) drive(dut, d[i], BIT);
    drive(dut, pbit, BIT);
    drive(dut, stopb, BIT);
    drive(dut, 1'b1, BIT);
    if (push_exp) begin
      if (dut == 8) exp8.push_back(model(d, nb, pm, pbit, stopb));
      else exp7.push_back(model(d, nb, pm, pbit, stopb));
    end
  endtask

  task automatic compare(input int dut, input string tag);
    if (dut == 8) begin
      check_eq({tag, " count"}, 32'(obs8.size()), 32'(exp8.size()));
      while (obs8.size() > 0 && exp8.size() > 0)
        check_eq({tag, " word"}, 32'(obs8.pop_front()), 32'(exp8.pop_front()));
      obs8.delete();
      exp8.delete();
    end else begin
      check_eq({tag, " count"}, 32'(obs7.size()), 32'(exp7.size()));
      while (obs7.size() > 0 && exp7.size() > 0)
        check_eq({tag, " word"}, 32'(obs7.pop_front()), 32'(exp7.pop_front()));
      obs7.delete();
      exp7.delete();
    end
  endtask

  initial begin
    logic [7:0] d;
    logic fp;
    logic sb;

    reset8 = 1'b0; reset7 = 1'b0;
    rxd8 = 1'b1; rxd7 = 1'b1;
    rdy8 = 1'b0; rdy7 = 1'b0;
    step(5);
    reset8 = 1'b1; reset7 = 1'b1;
    step(2);

    check_eq("rst valid8", 32'(val8), 32'(0));
    check_eq("rst data8", 32'(data8), 32'(0));
    check_eq("rst flags8", 32'({pe8, se8, bd8, ov8}), 32'(0));
    check_eq("rst valid7", 32'(val7), 32'(0));
    check_eq("rst flags7", 32'({data7, pe7, se7, bd7, ov7}), 32'(0));

    rdy8 = 1'b1;
    send_frame(8, 9'h0A5, 1'b0, 1'b1, 1'b1);
    compare(8, "a5");
    send_frame(8, 9'h03C, 1'b1, 1'b1, 1'b1);
    compare(8, "3c_par");
    send_frame(8, 9'h03C, 1'b0, 1'b0, 1'b1);
    compare(8, "3c_stop");

    drive(8, 1'b0, 40);
    drive(8, 1'b1, 3 * BIT);
    compare(8, "glitch");
    send_frame(8, 9'h05A, 1'b0, 1'b1, 1'b1);
    compare(8, "5a");

    // Held break: only one word while the line stays low.
    drive(8, 1'b0, 20 * BIT);
    exp8.push_back(model(9'h000, 8, 1, 1'b0, 1'b0));
    compare(8, "break");
    drive(8, 1'b1, BIT);
    send_frame(8, 9'h001, 1'b0, 1'b1, 1'b1);
    compare(8, "after_break");

    rdy8 = 1'b0;
    send_frame(8, 9'h011, 1'b0, 1'b1, 1'b0);
    send_frame(8, 9'h022, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("ovr valid", 32'(val8), 32'(1));
    check_eq("ovr data", 32'(data8), 32'h11);
    check_eq("ovr flag", 32'(ov8), 32'(1));
    check_eq("ovr errs", 32'({pe8, se8, bd8}), 32'(0));
    step(1);
    rdy8 = 1'b1;
    step(1);
    rdy8 = 1'b0;
    exp8.push_back(model(9'h011, 8, 1, 1'b0, 1'b1));
    @(negedge clk);
    check_eq("hs valid", 32'(val8), 32'(0));
    check_eq("hs overrun", 32'(ov8), 32'(0));
    step(1);
    compare(8, "ovr_hs");

    rdy8 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom_range(0, 255));
      fp = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        d  = 8'h00;
        fp = 1'b0;
        sb = 1'b0;
      end
      send_frame(8, {1'b0, d}, fp, sb, 1'b1);
      drive(8, 1'b1, $urandom_range(1, BIT));
      compare(8, "rand");
    end

    // 7O1: frame 0x78 cut by a one-cycle reset during data bit 3 must vanish.
    rdy7 = 1'b1;
    drive(7, 1'b0, 4 * BIT);
    drive(7, 1'b1, BIT / 2);
    reset7 = 1'b0;
    step(1);
    reset7 = 1'b1;
    drive(7, 1'b1, 12 * BIT);
    check_eq("abort valid", 32'(val7), 32'(0));
    compare(7, "abort");
    send_frame(7, 9'h07F, 1'b0, 1'b1, 1'b1);
    compare(7, "7f");
    send_frame(7, 9'h055, 1'b1, 1'b1, 1'b1);
    compare(7, "7o1_par");
    d = 8'($urandom_range(0, 127));
    send_frame(7, {1'b0, d}, 1'b0, 1'b1, 1'b1);
    compare(7, "7o1_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
